// File: rtl/hs_trace_pkg.sv
// Shared types and width helpers for the handshake trace buffer.
// The optional timestamp field is selected by the HS_TRACE_TS_EN macro.
package hs_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REC   = 2'd1,
        DRAIN = 2'd2,
        READ  = 2'd3
    } state_e;

    localparam int DROP_W = 8;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int entry_w(input int num_ch, input int ts_w, input int data_w, input bit ts_en);
        return ch_w(num_ch) + (ts_en ? ts_w : 0) + data_w;
    endfunction

endpackage

// File: rtl/hs_trace_rr_arb.sv
// Rotating-priority arbiter: picks one pending channel per cycle, priority
// restarts at the channel after the last winner and returns to ch0 on clr.
module hs_trace_rr_arb
    import hs_trace_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);

    localparam int IW = CH_W + 1;

    logic [CH_W-1:0] ptr_r;
    logic [CH_W-1:0] win_s;
    logic [IW-1:0]   idx_s;

    // Scan lowest priority first so the highest-priority requester lands last
    always_comb begin
        win_s = '0;
        idx_s = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr_r} + IW'(k);
            idx_s = (idx_s >= IW'(NUM_CH)) ? idx_s - IW'(NUM_CH) : idx_s;
            win_s = req[idx_s[CH_W-1:0]] ? idx_s[CH_W-1:0] : win_s;
        end
        grant = (|req) ? (NUM_CH'(1) << win_s) : '0;
    end

    // Priority pointer moves to the channel after the winner
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr_r <= '0;
        end else if (|req) begin
            ptr_r <= (win_s == CH_W'(NUM_CH - 1)) ? '0 : win_s + CH_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/hs_trace_buf.sv
// Snoops NUM_CH valid/ready channels into a circular trace RAM and replays it
// oldest-first. Define HS_TRACE_TS_EN to store a timestamp in each entry.
module hs_trace_buf
    import hs_trace_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int TS_W   = 16,
    localparam int CH_W  = ch_w(NUM_CH),
`ifdef HS_TRACE_TS_EN
    localparam int ENTRY_W = entry_w(NUM_CH, TS_W, DATA_W, 1'b1)
`else
    localparam int ENTRY_W = entry_w(NUM_CH, TS_W, DATA_W, 1'b0)
`endif
) (
    input  logic                       Clk,
    input  logic                       rst_n,
    input  logic                       DumpStart,
    input  logic                       DumpEnd,
    input  logic                       cfg_wrap,
    input  logic [NUM_CH-1:0]          mon_val,
    input  logic [NUM_CH-1:0]          mon_rdy,
    input  logic [NUM_CH*DATA_W-1:0]   mon_data,
    output logic                       rd_val,
    input  logic                       rd_rdy,
    output logic [ENTRY_W-1:0]         rd_data,
    output logic                       rd_last,
    output logic                       busy,
    output logic                       ovf,
    output logic [NUM_CH*DROP_W-1:0]   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e                    state_r, state_nx_s;
    logic                      busy_r, ovf_r, rd_val_r, rd_last_r;
    logic [ENTRY_W-1:0]        rd_data_r, wr_ent_s;
    logic [NUM_CH*DROP_W-1:0]  drop_cnt_r;
    logic [NUM_CH-1:0]         fire_s, pend_vld_r, grant_s, drop_s;
    logic [ENTRY_W-1:0]        pend_r    [NUM_CH];
    logic [ENTRY_W-1:0]        new_ent_s [NUM_CH];
    logic [ENTRY_W-1:0]        ram_r     [DEPTH];
    logic [AW-1:0]             wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]             cnt_r;
    logic                      rec_s, full_s, wr_en_s, rd_load_s;
`ifdef HS_TRACE_TS_EN
    logic [TS_W-1:0]           ts_r;
`endif

    hs_trace_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk   (Clk),
        .rst_n (rst_n),
        .clr   (DumpStart),
        .req   (pend_vld_r),
        .grant (grant_s)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Next-state decode; DumpStart restarts capture from any state
    always_comb begin
        state_nx_s = state_r;
        if (DumpStart) begin
            state_nx_s = REC;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = IDLE;
                REC:     state_nx_s = (DumpEnd || (full_s && !cfg_wrap)) ? DRAIN : REC;
                DRAIN:   state_nx_s = (pend_vld_r == '0) ? READ : DRAIN;
                READ:    state_nx_s = ((!rd_val_r && cnt_r == '0) || (rd_val_r && rd_rdy && rd_last_r)) ? IDLE : READ;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Capture, write and replay strobes derived from the current state
    always_comb begin
        rec_s     = (state_r == REC);
        fire_s    = rec_s ? (mon_val & mon_rdy) : '0;
        full_s    = (cnt_r == CW'(DEPTH));
        wr_en_s   = (|grant_s) && (!full_s || cfg_wrap) && !DumpStart;
        rd_load_s = (state_r == READ) && (cnt_r != '0) && (!rd_val_r || rd_rdy);
        // A grant into a full, non-wrapping RAM discards that pending entry
        drop_s    = (fire_s & pend_vld_r & ~grant_s) | (grant_s & {NUM_CH{full_s && !cfg_wrap}});
        wr_ent_s  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef HS_TRACE_TS_EN
            new_ent_s[i] = {CH_W'(i), ts_r, mon_data[i*DATA_W +: DATA_W]};
`else
            new_ent_s[i] = {CH_W'(i), mon_data[i*DATA_W +: DATA_W]};
`endif
            wr_ent_s = wr_ent_s | (pend_r[i] & {ENTRY_W{grant_s[i]}});
        end
    end

    // Pending registers, drop accounting, RAM pointers and the replay register
    always_ff @(posedge Clk) begin
        if (!rst_n || DumpStart) begin
            pend_vld_r <= '0;
            drop_cnt_r <= '0;
            ovf_r      <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            rd_val_r   <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_data_r  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_r[i] <= '0;
            end
`ifdef HS_TRACE_TS_EN
            ts_r       <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fire_s[i] && (!pend_vld_r[i] || grant_s[i])) begin
                    pend_r[i]     <= new_ent_s[i];
                    pend_vld_r[i] <= 1'b1;
                end else if (grant_s[i]) begin
                    pend_vld_r[i] <= 1'b0;
                end else begin
                    pend_vld_r[i] <= pend_vld_r[i];
                end
                if (drop_s[i] && drop_cnt_r[i*DROP_W +: DROP_W] != {DROP_W{1'b1}}) begin
                    drop_cnt_r[i*DROP_W +: DROP_W] <= drop_cnt_r[i*DROP_W +: DROP_W] + DROP_W'(1);
                end
            end
            if ((|drop_s) || (wr_en_s && full_s)) begin
                ovf_r <= 1'b1;
            end
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                if (full_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else if (rd_load_s) begin
                rd_data_r <= ram_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                cnt_r     <= cnt_r - CW'(1);
                rd_val_r  <= 1'b1;
                rd_last_r <= (cnt_r == CW'(1));
            end else if (rd_val_r && rd_rdy) begin
                rd_val_r  <= 1'b0;
                rd_last_r <= 1'b0;
            end
`ifdef HS_TRACE_TS_EN
            if (rec_s) begin
                ts_r <= ts_r + TS_W'(1);
            end
`endif
        end
    end

    // Trace RAM write port
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            ram_r[wr_ptr_r] <= wr_ent_s;
        end
    end

    assign rd_val   = rd_val_r;
    assign rd_data  = rd_data_r;
    assign rd_last  = rd_last_r;
    assign busy     = busy_r;
    assign ovf      = ovf_r;
    assign drop_cnt = drop_cnt_r;

endmodule
